// File: rtl/radio_deserializer_pkg.sv
// Shared framing constants and state encoding for the radio serial link.
// Both the serializer and the deserializer use this package.
package radio_deserializer_pkg;

    localparam int FRAME_BITS = 8;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } deser_state_e;

endpackage

// File: rtl/radio_deserializer_sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head word, synchronous active-low reset.
// A push and a pop in the same cycle are both honoured, even when the FIFO is full.
module sync_fifo
    import radio_deserializer_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS,
    parameter int DEPTH = 4
) (
    input  logic             SYS_CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             do_rd;
    logic             do_wr;

    assign do_rd      = rd_en && (count_reg != '0);
    assign do_wr      = wr_en && ((count_reg != FULL_CNT) || do_rd);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    always_ff @(posedge SYS_CLK) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_inc;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head register tracks the next word to present; an incoming word that
    // becomes the head in this cycle bypasses the array.
    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            head_reg <= '0;
        end else if (do_rd) begin
            if (count_reg == (AW + 1)'(1)) begin
                if (do_wr) head_reg <= wr_data;
            end else begin
                head_reg <= mem[rd_ptr_inc];
            end
        end else if (do_wr && (count_reg == '0)) begin
            head_reg <= wr_data;
        end
    end

    assign rd_data = head_reg;
    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/radio_deserializer.sv
// radio_deserializer: recovers 8-bit LSB-first frames from the serial link using SYNC,
// buffers them in sync_fifo. Optional counters under macro RADIO_DESER_STATS_EN.
module radio_deserializer
    import radio_deserializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LOCK_LOSS  = 3
) (
    input  logic                  SYS_CLK,
    input  logic                  RST_N,
    input  logic                  SER_DATA,
    input  logic                  SER_SYNC,
    output logic [FRAME_BITS-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  LOCKED,
    output logic                  OVERFLOW
`ifdef RADIO_DESER_STATS_EN
    ,
    output logic [31:0]           FRAME_CNT,
    output logic [15:0]           SYNC_ERR_CNT
`endif
);

    localparam int CW = $clog2(FRAME_BITS);
    localparam int MW = $clog2(LOCK_LOSS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    deser_state_e          state_reg, state_next;
    logic [CW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [MW-1:0]         miss_cnt_reg, miss_cnt_next;
    logic [FRAME_BITS-1:0] sr_reg, sr_next;
    logic [FRAME_BITS-1:0] frame_word_reg, frame_word_next;
    logic                  frame_done_reg, frame_done_next;
    logic                  data_reg, sync_reg;
    logic                  overflow_reg;
    logic                  sync_err_evt;
    logic                  fifo_full, fifo_empty;
    logic                  push_ok;

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            state_reg      <= ST_HUNT;
            bit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
            sr_reg         <= '0;
            frame_word_reg <= '0;
            frame_done_reg <= 1'b0;
            data_reg       <= 1'b0;
            sync_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            miss_cnt_reg   <= miss_cnt_next;
            sr_reg         <= sr_next;
            frame_word_reg <= frame_word_next;
            frame_done_reg <= frame_done_next;
            data_reg       <= SER_DATA;
            sync_reg       <= SER_SYNC;
            if (frame_done_reg && fifo_full && !OUT_READY) overflow_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        miss_cnt_next   = miss_cnt_reg;
        sr_next         = sr_reg;
        frame_word_next = frame_word_reg;
        frame_done_next = 1'b0;
        sync_err_evt    = 1'b0;
        case (state_reg)
            ST_HUNT: begin
                if (sync_reg) begin
                    sr_next[0]    = data_reg;
                    bit_cnt_next  = CW'(1);
                    miss_cnt_next = '0;
                    state_next    = ST_LOCKED;
                end
            end
            default: begin
                if (sync_reg && (bit_cnt_reg != '0)) begin
                    // Misplaced marker: abandon the partial frame and realign on it.
                    sr_next[0]    = data_reg;
                    bit_cnt_next  = CW'(1);
                    miss_cnt_next = '0;
                    sync_err_evt  = 1'b1;
                end else begin
                    sr_next[bit_cnt_reg] = data_reg;
                    bit_cnt_next         = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        frame_done_next = 1'b1;
                        frame_word_next = sr_next;
                    end
                    if (bit_cnt_reg == '0) begin
                        if (sync_reg) begin
                            miss_cnt_next = '0;
                        end else begin
                            // Flywheel through missing markers until the loss limit.
                            sync_err_evt = 1'b1;
                            if (miss_cnt_reg == MW'(LOCK_LOSS - 1)) begin
                                state_next    = ST_HUNT;
                                bit_cnt_next  = '0;
                                miss_cnt_next = '0;
                            end else begin
                                miss_cnt_next = miss_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SYS_CLK (SYS_CLK),
        .RST_N   (RST_N),
        .wr_en   (frame_done_reg),
        .wr_data (frame_word_reg),
        .rd_en   (OUT_READY),
        .rd_data (OUT_DATA),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign push_ok   = frame_done_reg && (!fifo_full || OUT_READY);
    assign OUT_VALID = !fifo_empty;
    assign LOCKED    = (state_reg == ST_LOCKED);
    assign OVERFLOW  = overflow_reg;

`ifdef RADIO_DESER_STATS_EN
    logic [31:0] frame_cnt_reg;
    logic [15:0] sync_err_cnt_reg;

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            frame_cnt_reg    <= '0;
            sync_err_cnt_reg <= '0;
        end else begin
            if (push_ok) frame_cnt_reg <= frame_cnt_reg + 1'b1;
            if (sync_err_evt && (sync_err_cnt_reg != 16'hFFFF))
                sync_err_cnt_reg <= sync_err_cnt_reg + 1'b1;
        end
    end

    assign FRAME_CNT    = frame_cnt_reg;
    assign SYNC_ERR_CNT = sync_err_cnt_reg;
`else
    logic stats_unused;
    assign stats_unused = sync_err_evt | push_ok;
`endif

endmodule

// File: tb/tb_radio_deserializer.sv
// Bench for radio_deserializer: directed frame sequences with random payloads,
// checked against a frame-level expected-word queue.
module tb_radio_deserializer;

    logic       SYS_CLK = 1'b0;
    logic       RST_N;
    logic       SER_DATA;
    logic       SER_SYNC;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       LOCKED;
    logic       OVERFLOW;
`ifdef RADIO_DESER_STATS_EN
    logic [31:0] FRAME_CNT;
    logic [15:0] SYNC_ERR_CNT;
`endif

    radio_deserializer #(
        .FIFO_DEPTH (4),
        .LOCK_LOSS  (3)
    ) dut (
        .SYS_CLK   (SYS_CLK),
        .RST_N     (RST_N),
        .SER_DATA  (SER_DATA),
        .SER_SYNC  (SER_SYNC),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .LOCKED    (LOCKED),
        .OVERFLOW  (OVERFLOW)
`ifdef RADIO_DESER_STATS_EN
        ,
        .FRAME_CNT    (FRAME_CNT),
        .SYNC_ERR_CNT (SYNC_ERR_CNT)
`endif
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       obs_valid, obs_locked, obs_ovf;
    logic [7:0] obs_data;
    logic [2:0] vrec;
    logic [7:0] w1, w2, w3, wa, wb, wc, wd, we, q3;
    logic [7:0] p[1:7];
    logic [7:0] s[1:6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bit time: sample outputs at the falling edge, then drive the next bit.
    task automatic tick(input logic d, input logic sy, input logic r, input logic rn);
        logic [7:0] e;
        @(negedge SYS_CLK);
        obs_valid  = OUT_VALID;
        obs_locked = LOCKED;
        obs_ovf    = OVERFLOW;
        obs_data   = OUT_DATA;
        SER_DATA   = d;
        SER_SYNC   = sy;
        OUT_READY  = r;
        RST_N      = rn;
        if (rn && r && OUT_VALID) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_word: observed %02h expected none", OUT_DATA);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("t=%0t accepted word %02h (expected %02h)", $time, OUT_DATA, e);
                check("out_data", 32'(OUT_DATA), 32'(e));
            end
        end
    endtask

    // sync_pos 0 = marker on bit 0, 8 = no marker; rdy gives OUT_READY per bit.
    task automatic send_frame(input logic [7:0] w, input int sync_pos, input bit expect_out,
                              input logic [7:0] rdy);
        if (expect_out) exp_q.push_back(w);
        for (int b = 0; b < 8; b++) tick(w[b], (b == sync_pos), rdy[b], 1'b1);
    endtask

    initial begin
        RST_N = 1'b0; SER_DATA = 1'b0; SER_SYNC = 1'b0; OUT_READY = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_valid", 32'(obs_valid), 0);
        check("reset_data", 32'(obs_data), 0);
        check("reset_locked", 32'(obs_locked), 0);
        check("reset_overflow", 32'(obs_ovf), 0);

        // Two aligned frames, OUT_VALID three edges after bit 7
        send_frame(8'hA5, 0, 1'b1, 8'hFF);
        exp_q.push_back(8'h3C);
        w1 = 8'h3C;
        for (int b = 0; b < 8; b++) begin
            tick(w1[b], (b == 0), 1'b1, 1'b1);
            if (b == 0) check("t1_locked", 32'(obs_locked), 1);
            if (b < 3) vrec[b] = obs_valid;
        end
        check("t1_valid_e0", 32'(vrec[0]), 0);
        check("t1_valid_e1", 32'(vrec[1]), 0);
        check("t1_valid_e2", 32'(vrec[2]), 1);

        // Marker moved to bit 3: realign, keep lock
        w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
        send_frame(w1, 0, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) tick(1'($urandom), (i == 0), 1'b1, 1'b1);
        send_frame(w2, 0, 1'b1, 8'hFF);
        check("t3_locked", 32'(LOCKED), 1);
        send_frame(w3, 0, 1'b1, 8'hFF);

        // Markers lost: two flywheel frames, then lock dropped
        wa = 8'($urandom); wb = 8'($urandom); wc = 8'($urandom);
        wd = 8'($urandom); we = 8'($urandom);
        send_frame(wa, 8, 1'b1, 8'hFF);
        send_frame(wb, 8, 1'b1, 8'hFF);
        check("t4_locked_b", 32'(LOCKED), 1);
        send_frame(wc, 8, 1'b0, 8'hFF);
        check("t4_unlocked_c", 32'(LOCKED), 0);
        send_frame(wd, 8, 1'b0, 8'hFF);
        check("t4_unlocked_d", 32'(LOCKED), 0);
        send_frame(we, 0, 1'b1, 8'hFF);
        check("t4_relocked", 32'(LOCKED), 1);

        // Consumer stalled for six frames: four held, overflow sticky
        for (int i = 1; i <= 7; i++) p[i] = 8'($urandom);
        send_frame(p[1], 0, 1'b1, 8'h1F);
        for (int i = 2; i <= 4; i++) send_frame(p[i], 0, 1'b1, 8'h00);
        send_frame(p[5], 0, 1'b0, 8'h00);
        check("t2_no_overflow_yet", 32'(OVERFLOW), 0);
        send_frame(p[6], 0, 1'b0, 8'h00);
        check("t2_overflow", 32'(OVERFLOW), 1);
        check("t2_valid_held", 32'(OUT_VALID), 1);
        check("t2_head_stable", 32'(OUT_DATA), 32'(p[1]));
        send_frame(p[7], 0, 1'b1, 8'hF8);

        // Reset at bit 4 with two words queued
        w1 = 8'($urandom); w2 = 8'($urandom); q3 = 8'($urandom);
        send_frame(w1, 0, 1'b1, 8'h1F);
        send_frame(w2, 0, 1'b1, 8'h00);
        for (int b = 0; b < 4; b++) tick(q3[b], (b == 0), 1'b0, 1'b1);
        check("t5_queued_head", 32'(OUT_DATA), 32'(w1));
        exp_q.delete();
        tick(q3[4], 1'b0, 1'b0, 1'b0);
        tick(q3[5], 1'b0, 1'b0, 1'b1);
        check("t5_valid", 32'(obs_valid), 0);
        check("t5_overflow", 32'(obs_ovf), 0);
        check("t5_locked", 32'(obs_locked), 0);
        check("t5_data", 32'(obs_data), 0);
        tick(q3[6], 1'b0, 1'b0, 1'b1);
        tick(q3[7], 1'b0, 1'b0, 1'b1);
        w3 = 8'($urandom);
        send_frame(w3, 0, 1'b1, 8'hFF);

        // Full FIFO: push and pop on the same edge
        for (int i = 1; i <= 6; i++) s[i] = 8'($urandom);
        send_frame(s[1], 0, 1'b1, 8'h1F);
        for (int i = 2; i <= 5; i++) send_frame(s[i], 0, 1'b1, 8'h00);
        check("t6_full_valid", 32'(OUT_VALID), 1);
        send_frame(s[6], 0, 1'b1, 8'hFE);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("t6_overflow", 32'(OVERFLOW), 0);
        check("t6_locked", 32'(LOCKED), 1);
        check("drain_empty", 32'(exp_q.size()), 0);
        check("final_valid", 32'(OUT_VALID), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
